// File: rtl/matrix_engine_seq.sv
// Sequential DIMxDIM matrix engine: MUL, ADD, SUB, TRANSPOSE through one shared MAC/adder.
// Define MATRIX_ENGINE_SAT_EN to saturate results instead of wrapping them modulo 2^W.
module matrix_engine_seq #(
  parameter int DIM   = 4,
  parameter int W     = 16,
  parameter int ACC_W = 34
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic [DIM*DIM*W-1:0] data_in,
  input  logic                 load_a,
  input  logic                 load_b,
  input  logic [1:0]           op,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  output logic [DIM*DIM*W-1:0] result
);

  localparam int CW = $clog2(DIM);
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_TRN = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [CW-1:0]        r_q, r_d, c_q, c_d, k_q, k_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [W-1:0]         a_q    [DIM][DIM];
  logic [W-1:0]         b_q    [DIM][DIM];
  logic [W-1:0]         work_q [DIM][DIM];
  logic [W-1:0]         work_d [DIM][DIM];
  logic [W-1:0]         inMat  [DIM][DIM];
  logic [DIM*DIM*W-1:0] result_q, result_d;
  logic                 resultValid_q, resultValid_d;
  logic                 loadAEn, loadBEn;

  logic [W-1:0]         opA, opB, elem, diff;
  logic [ACC_W-1:0]     product, macSum;
  logic                 elemWe, lastStep, stepC;
`ifdef MATRIX_ENGINE_SAT_EN
  logic [W:0]           addSum;
`else
  logic [W-1:0]         addSum;
`endif

  always_comb begin
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        inMat[r][c] = data_in[(DIM*DIM-1-(r*DIM+c))*W +: W];
      end
    end
  end

  // Datapath for the element addressed by the current (r,c,k) counters.
  always_comb begin
    opA     = a_q[r_q][c_q];
    opB     = b_q[r_q][c_q];
    product = ACC_W'(a_q[r_q][k_q]) * ACC_W'(b_q[k_q][c_q]);
    macSum  = ((k_q == '0) ? '0 : acc_q) + product;
    diff    = opA - opB;
`ifdef MATRIX_ENGINE_SAT_EN
    addSum  = {1'b0, opA} + {1'b0, opB};
`else
    addSum  = opA + opB;
`endif
    elem    = '0;
    case (op_q)
`ifdef MATRIX_ENGINE_SAT_EN
      OP_MUL:  elem = (|macSum[ACC_W-1:W]) ? '1 : macSum[W-1:0];
      OP_ADD:  elem = addSum[W] ? '1 : addSum[W-1:0];
      OP_SUB:  elem = (opA < opB) ? '0 : diff;
`else
      OP_MUL:  elem = macSum[W-1:0];
      OP_ADD:  elem = addSum;
      OP_SUB:  elem = diff;
`endif
      OP_TRN:  elem = a_q[c_q][r_q];
      default: elem = '0;
    endcase
    elemWe   = (op_q != OP_MUL) || (k_q == LAST);
    stepC    = elemWe;
    lastStep = (r_q == LAST) && (c_q == LAST) && elemWe;
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    r_d           = r_q;
    c_d           = c_q;
    k_d           = k_q;
    acc_d         = acc_q;
    work_d        = work_q;
    result_d      = result_q;
    resultValid_d = resultValid_q;
    loadAEn       = 1'b0;
    loadBEn       = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_a || load_b) begin
          loadAEn       = load_a;
          loadBEn       = load_b;
          resultValid_d = 1'b0;
        end else if (start) begin
          op_d    = op;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (op_q == OP_MUL) begin
          acc_d = macSum;
          k_d   = (k_q == LAST) ? '0 : k_q + CW'(1);
        end
        if (elemWe) begin
          work_d[r_q][c_q] = elem;
        end
        if (stepC) begin
          c_d = (c_q == LAST) ? '0 : c_q + CW'(1);
          if (c_q == LAST) begin
            r_d = (r_q == LAST) ? '0 : r_q + CW'(1);
          end
        end
        // The final element bypasses work_q so result updates together with done.
        if (lastStep) begin
          state_d       = DONE;
          resultValid_d = 1'b1;
          for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
              result_d[(DIM*DIM-1-(r*DIM+c))*W +: W] = work_d[r][c];
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= IDLE;
      op_q          <= OP_MUL;
      r_q           <= '0;
      c_q           <= '0;
      k_q           <= '0;
      acc_q         <= '0;
      result_q      <= '0;
      resultValid_q <= 1'b0;
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          a_q[r][c]    <= '0;
          b_q[r][c]    <= '0;
          work_q[r][c] <= '0;
        end
      end
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      r_q           <= r_d;
      c_q           <= c_d;
      k_q           <= k_d;
      acc_q         <= acc_d;
      result_q      <= result_d;
      resultValid_q <= resultValid_d;
      work_q        <= work_d;
      if (loadAEn) begin
        a_q <= inMat;
      end
      if (loadBEn) begin
        b_q <= inMat;
      end
    end
  end

  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign result_valid = resultValid_q;
  assign result       = result_q;

endmodule

// File: tb/tb_matrix_engine_seq.sv
// Scoreboard testbench for matrix_engine_seq: directed vectors plus random ops vs. a matrix-arithmetic model.
// Honours MATRIX_ENGINE_SAT_EN when the design is built with saturation.
module tb_matrix_engine_seq;

  localparam int DIM = 4;
  localparam int W   = 16;
  localparam int FW  = DIM*DIM*W;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_TRN = 2'b11;

  logic          clk = 1'b0;
  logic          nReset = 1'b0;
  logic [FW-1:0] data_in = '0;
  logic          load_a = 1'b0;
  logic          load_b = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          start = 1'b0;
  logic          busy, done, result_valid;
  logic [FW-1:0] result;

  matrix_engine_seq #(.DIM(DIM), .W(W), .ACC_W(34)) dut (
    .clk(clk), .nReset(nReset), .data_in(data_in), .load_a(load_a), .load_b(load_b),
    .op(op), .start(start), .busy(busy), .done(done), .result_valid(result_valid), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] res;
    int            startEdge;
    int            lat;
  } exp_t;

  exp_t          expQ[$];
  int            compared = 0;
  int            mismatched = 0;
  int            edgeCnt = 0;
  int            busyCnt = 0;
  int            doneCnt = 0;
  logic [FW-1:0] refA = '0;
  logic [FW-1:0] refB = '0;

  always @(posedge clk) edgeCnt++;

  function automatic void checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic longint el(input logic [FW-1:0] m, input int r, input int c);
    longint v;
    v = m[(DIM*DIM-1-(r*DIM+c))*W +: W];
    return v;
  endfunction

  // Reference: plain integer matrix arithmetic, then wrap or clamp to W bits.
  function automatic logic [FW-1:0] model(input logic [1:0] o, input logic [FW-1:0] fa, input logic [FW-1:0] fb);
    logic [FW-1:0] res;
    longint s;
    longint maxv;
    maxv = (longint'(1) << W) - 1;
    res  = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        s = 0;
        case (o)
          OP_MUL: for (int k = 0; k < DIM; k++) s += el(fa, r, k) * el(fb, k, c);
          OP_ADD: s = el(fa, r, c) + el(fb, r, c);
          OP_SUB: s = el(fa, r, c) - el(fb, r, c);
          default: s = el(fa, c, r);
        endcase
`ifdef MATRIX_ENGINE_SAT_EN
        if (s > maxv) s = maxv;
        if (s < 0) s = 0;
`else
        s = s & maxv;
`endif
        res[(DIM*DIM-1-(r*DIM+c))*W +: W] = s[W-1:0];
      end
    end
    return res;
  endfunction

  function automatic logic [FW-1:0] fillMat(input logic [W-1:0] v);
    logic [FW-1:0] m;
    for (int i = 0; i < DIM*DIM; i++) m[i*W +: W] = v;
    return m;
  endfunction

  function automatic logic [FW-1:0] randMat();
    logic [FW-1:0] m;
    for (int i = 0; i < DIM*DIM; i++) m[i*W +: W] = W'($urandom);
    return m;
  endfunction

  function automatic int opLat(input logic [1:0] o);
    return (o == OP_MUL) ? DIM*DIM*DIM : DIM*DIM;
  endfunction

  // Monitor: every done pops one expectation and checks data, latency and busy length.
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      busyCnt++;
    end else if (done) begin
      doneCnt++;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        e = expQ.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("done_latency", FW'(edgeCnt - e.startEdge), FW'(e.lat));
        checkOutput("busy_cycles", FW'(busyCnt), FW'(e.lat));
        checkOutput("valid_at_done", FW'(result_valid), FW'(1));
      end
      busyCnt = 0;
    end else begin
      busyCnt = 0;
    end
  end

  task automatic pulse(input logic la, input logic lb, input logic st, input logic [1:0] o, input logic [FW-1:0] d);
    @(negedge clk);
    load_a = la; load_b = lb; start = st; op = o; data_in = d;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0; start = 1'b0;
  endtask

  task automatic loadA(input logic [FW-1:0] d);
    pulse(1'b1, 1'b0, 1'b0, OP_MUL, d);
    refA = d;
  endtask

  task automatic loadB(input logic [FW-1:0] d);
    pulse(1'b0, 1'b1, 1'b0, OP_MUL, d);
    refB = d;
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [FW-1:0] expRes);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o;
    e.res = expRes; e.startEdge = edgeCnt + 1; e.lat = opLat(o);
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL done_timeout: got no done expected done within 2000 cycles");
      expQ.delete();
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [FW-1:0] specA, specB, firstRes, newA;
    int donesBefore;
    logic [1:0] o;

    specA = 256'h0005_0008_0006_0002_0007_0003_0008_0004_0006_0005_0001_0003_0008_0005_0007_0009;
    specB = 256'h000b_000e_0013_0012_0006_0009_0004_0005_000c_000a_000f_000e_0006_0003_0008_0007;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", FW'(busy), FW'(0));
    checkOutput("reset_done", FW'(done), FW'(0));
    checkOutput("reset_valid", FW'(result_valid), FW'(0));
    checkOutput("reset_result", result, '0);
    nReset = 1'b1;

    $display("[TB] directed MUL and TRANSPOSE");
    loadA(specA);
    loadB(specB);
    applyStimulus(OP_MUL, 256'h00bb_00d0_00e9_00e4_00d7_00d9_0129_0119_007e_0094_00ad_00a8_0100_00fe_015d_014a);
    waitDone();
    applyStimulus(OP_TRN, 256'h0005_0007_0006_0008_0008_0003_0005_0005_0006_0008_0001_0007_0002_0004_0003_0009);
    waitDone();

    $display("[TB] overflow cases");
    loadA(fillMat(16'hFFFF));
    loadB(fillMat(16'h0002));
`ifdef MATRIX_ENGINE_SAT_EN
    applyStimulus(OP_ADD, fillMat(16'hFFFF));
`else
    applyStimulus(OP_ADD, fillMat(16'h0001));
`endif
    waitDone();
    applyStimulus(OP_MUL, model(OP_MUL, refA, refB));
    waitDone();
    loadA(fillMat(16'h0001));
`ifdef MATRIX_ENGINE_SAT_EN
    applyStimulus(OP_SUB, fillMat(16'h0000));
`else
    applyStimulus(OP_SUB, fillMat(16'hFFFF));
`endif
    waitDone();

    $display("[TB] start together with load_a");
    newA = randMat();
    pulse(1'b1, 1'b0, 1'b1, OP_TRN, newA);
    refA = newA;
    checkOutput("start_load_busy", FW'(busy), FW'(0));
    checkOutput("start_load_valid", FW'(result_valid), FW'(0));
    repeat (25) @(negedge clk);
    applyStimulus(OP_TRN, model(OP_TRN, refA, refB));
    waitDone();

    $display("[TB] load_b and start during RUN");
    loadB(randMat());
    donesBefore = doneCnt;
    applyStimulus(OP_MUL, model(OP_MUL, refA, refB));
    repeat (5) @(negedge clk);
    pulse(1'b0, 1'b1, 1'b0, OP_MUL, randMat());
    pulse(1'b0, 1'b0, 1'b1, OP_ADD, '0);
    waitDone();
    repeat (80) @(negedge clk);
    checkOutput("single_done", FW'(doneCnt - donesBefore), FW'(1));
    applyStimulus(OP_ADD, model(OP_ADD, refA, refB));
    waitDone();

    $display("[TB] back-to-back operations");
    loadA(randMat());
    loadB(randMat());
    firstRes = model(OP_MUL, refA, refB);
    applyStimulus(OP_MUL, firstRes);
    waitDone();
    applyStimulus(OP_SUB, model(OP_SUB, refA, refB));
    repeat (6) @(negedge clk);
    checkOutput("result_hold", result, firstRes);
    checkOutput("valid_hold", FW'(result_valid), FW'(1));
    waitDone();

    $display("[TB] random operations");
    for (int i = 0; i < 8; i++) begin
      loadA(randMat());
      loadB(randMat());
      o = 2'($urandom_range(0, 3));
      applyStimulus(o, model(o, refA, refB));
      waitDone();
    end

    $display("[TB] reset during MUL");
    applyStimulus(OP_MUL, model(OP_MUL, refA, refB));
    repeat (20) @(negedge clk);
    #2 nReset = 1'b0;
    expQ.delete();
    refA = '0;
    refB = '0;
    #1;
    checkOutput("abort_busy", FW'(busy), FW'(0));
    checkOutput("abort_result", result, '0);
    checkOutput("abort_valid", FW'(result_valid), FW'(0));
    @(negedge clk);
    nReset = 1'b1;
    repeat (80) @(negedge clk);
    checkOutput("abort_no_valid", FW'(result_valid), FW'(0));
    loadA(randMat());
    applyStimulus(OP_TRN, model(OP_TRN, refA, refB));
    waitDone();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
